ml_out_serializer: RTL
======================

ML_OUT_SERIALIZER -- requirements
Module: ml_out_serializer

Interface
REQ-001 SHALL have parameter WORD_W, default 8, width of each hard-decision word from the detector.
REQ-002 SHALL have parameter OUT_W, default 1, bits per output beat; WORD_W SHALL be an integer multiple of OUT_W.
REQ-003 SHALL have parameter DEPTH, default 16, FIFO depth in words; power of two, >= 2.
REQ-004 SHALL have port i_clk  input  1  single clock, rising edge.
REQ-005 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_x_valid  input  1  upstream word valid.
REQ-007 SHALL have port o_x_ready  output  1  upstream may transfer this cycle.
REQ-008 SHALL have port i_x_hard_bit  input  WORD_W  upstream hard-decision word.
REQ-009 SHALL have port i_msb_first  input  1  bit order for the word being loaded (0 = LSB first).
REQ-010 SHALL have port i_rd_rdy  input  1  downstream ready.
REQ-011 SHALL have port o_rd_vld  output  1  output beat valid.
REQ-012 SHALL have port o_hard_bit  output  OUT_W  current output beat.
REQ-013 SHALL have port o_last  output  1  current beat is the final beat of its word.
REQ-014 SHALL have port o_level  output  clog2(DEPTH+1)  words held in FIFO (excludes word in shifter).

Function
REQ-015 SHALL define BEATS = WORD_W/OUT_W; beat counter width max(1,clog2(BEATS)).
REQ-016 SHALL accept an input word when i_x_valid & o_x_ready; o_x_ready SHALL equal ~full (registered-state only; no combinational path from i_rd_rdy).
REQ-017 SHALL never drop or duplicate an accepted word; order preserved.
REQ-018 SHALL issue a "load" when ~o_rd_vld, or o_rd_vld & i_rd_rdy & o_last.
REQ-019 On load with FIFO non-empty SHALL pop FIFO head into the shifter; an accepted input word the same cycle SHALL be pushed.
REQ-020 On load with FIFO empty and an input accepted SHALL bypass it into the shifter (not pushed); o_rd_vld high next cycle (1-cycle latency).
REQ-021 On load with nothing available SHALL deassert o_rd_vld next cycle.
REQ-022 Otherwise an accepted input SHALL be pushed to FIFO; push at full SHALL be impossible (o_x_ready low) even if a pop occurs that cycle.
REQ-023 i_msb_first SHALL be sampled at word acceptance and stored with the word (FIFO width WORD_W+1).
REQ-024 LSB-first: beat k SHALL be word[k*OUT_W +: OUT_W]; MSB-first: beat k SHALL be word[WORD_W-1-k*OUT_W -: OUT_W].
REQ-025 Beat counter SHALL advance only on o_rd_vld & i_rd_rdy, reset to 0 on load; o_last = (cnt == BEATS-1).
REQ-026 o_hard_bit and o_last SHALL hold stable while o_rd_vld & ~i_rd_rdy.
REQ-027 o_level SHALL update the cycle after each push/pop; simultaneous push+pop leaves it unchanged.
REQ-028 BEATS = 1 SHALL make every beat o_last = 1.

Reset
REQ-029 i_reset SHALL asynchronously clear FIFO pointers, beat counter, shifter; outputs: o_rd_vld 0, o_hard_bit 0, o_last 0 (when BEATS>1), o_level 0, o_x_ready 1 after release.
REQ-030 Reset mid-word SHALL discard the partial word and all FIFO contents; no beat emitted after release until a new accept.

Structure
REQ-031 clog2 helper and bit-order mode constants SHALL live in shared package ml_pkg.
REQ-032 FIFO SHALL be sub-module ml_sync_fifo (parameters DATA_WIDTH, DEPTH; ports wen, ren, wdata, rdata first-word-fall-through, full, empty, level).
REQ-033 Shifter, beat counter and load/bypass control SHALL be in ml_out_serializer itself.

Verification
REQ-034 WORD_W=8, OUT_W=1: accept 8'hA5, LSB-first, i_rd_rdy=1 -> beats 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after accept, o_last on 8th, then o_rd_vld=0.
REQ-035 OUT_W=2, MSB-first, accept 8'hC6 -> beats 2'b11,00,01,10, o_last on 4th.
REQ-036 DEPTH=4, i_rd_rdy=0, push 6 words -> 1 in shifter, 4 in FIFO, o_level=4, o_x_ready=0; release -> all 5 emitted in order, 6th accepted only after pop.
REQ-037 Back-to-back words with i_rd_rdy=1 -> no idle cycle between o_last beat and next word's first beat.
REQ-038 Random i_rd_rdy stalls -> o_hard_bit/o_last stable during stalls; output stream matches scoreboard.
REQ-039 Assert i_reset during beat 3 of word with 2 queued -> o_rd_vld=0, o_level=0 immediately; no stale beats after release.

Source files
------------

// File: rtl/ml_pkg.sv
// Shared helpers and constants for the ML hard-decision output path.
// Holds the ceil-log2 helper and the bit-order mode encoding stored with each word.
package ml_pkg;

    localparam logic MODE_LSB_FIRST = 1'b0;
    localparam logic MODE_MSB_FIRST = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ml_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data and an occupancy count.
// Writes while full and reads while empty are ignored.
module ml_sync_fifo
    import ml_pkg::*;
#(
    parameter int DATA_WIDTH = 9,
    parameter int DEPTH      = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        wen,
    input  logic                        ren,
    input  logic [DATA_WIDTH-1:0]       wdata,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic                        full,
    output logic                        empty,
    output logic [clog2(DEPTH+1)-1:0]   level
);

    localparam int AW = clog2(DEPTH);
    localparam int LW = clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  do_wr;
    logic                  do_rd;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];
    assign do_wr = wen & ~full;
    assign do_rd = ren & ~empty;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_wr, do_rd})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/ml_out_serializer.sv
// Buffers hard-decision words and serialises each into OUT_W-bit beats, LSB or MSB first.
// Handshake: a word moves on i_x_valid & o_x_ready, a beat moves on o_rd_vld & i_rd_rdy.
module ml_out_serializer
    import ml_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int OUT_W  = 1,
    parameter int DEPTH  = 16
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_x_valid,
    output logic                        o_x_ready,
    input  logic [WORD_W-1:0]           i_x_hard_bit,
    input  logic                        i_msb_first,
    input  logic                        i_rd_rdy,
    output logic                        o_rd_vld,
    output logic [OUT_W-1:0]            o_hard_bit,
    output logic                        o_last,
    output logic [clog2(DEPTH+1)-1:0]   o_level
);

    localparam int BEATS = WORD_W / OUT_W;
    localparam int CW    = max_int(1, clog2(BEATS));
    localparam int FW    = WORD_W + 1;

    logic              fifo_wen;
    logic              fifo_ren;
    logic [FW-1:0]     fifo_wdata;
    logic [FW-1:0]     fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;

    logic              vld_q, vld_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              msb_q, msb_d;

    logic              accept;
    logic              beat_last;
    logic              load;

    // Ready depends only on registered FIFO state; a pop in the same cycle
    // never frees a slot for the incoming word.
    assign o_x_ready  = ~fifo_full;
    assign accept     = i_x_valid & ~fifo_full;
    assign beat_last  = (cnt_q == CW'(BEATS - 1));
    assign load       = ~vld_q | (i_rd_rdy & beat_last);
    assign fifo_wdata = {i_msb_first, i_x_hard_bit};

    ml_sync_fifo #(
        .DATA_WIDTH (FW),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk_i (i_clk),
        .rst_i (i_reset),
        .wen   (fifo_wen),
        .ren   (fifo_ren),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (o_level)
    );

    always_comb begin
        vld_d    = vld_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        msb_d    = msb_q;
        fifo_ren = 1'b0;
        fifo_wen = accept;
        if (load) begin
            cnt_d = '0;
            if (!fifo_empty) begin
                fifo_ren = 1'b1;
                shift_d  = fifo_rdata[WORD_W-1:0];
                msb_d    = fifo_rdata[WORD_W];
                vld_d    = 1'b1;
            end else if (accept) begin
                // Empty FIFO: the incoming word skips the queue entirely.
                fifo_wen = 1'b0;
                shift_d  = i_x_hard_bit;
                msb_d    = i_msb_first;
                vld_d    = 1'b1;
            end else begin
                vld_d = 1'b0;
            end
        end else if (i_rd_rdy) begin
            // The current beat always sits at the exit end of the shifter.
            cnt_d = cnt_q + 1'b1;
            if (msb_q == MODE_MSB_FIRST) begin
                shift_d = shift_q << OUT_W;
            end else begin
                shift_d = shift_q >> OUT_W;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vld_q   <= 1'b0;
            cnt_q   <= '0;
            shift_q <= '0;
            msb_q   <= MODE_LSB_FIRST;
        end else begin
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            msb_q   <= msb_d;
        end
    end

    assign o_rd_vld   = vld_q;
    assign o_last     = beat_last;
    assign o_hard_bit = (msb_q == MODE_MSB_FIRST) ? shift_q[WORD_W-1 -: OUT_W]
                                                  : shift_q[OUT_W-1:0];

endmodule
